// File: rtl/uart_io_pkg.sv
// uart_io_pkg: shared constants for the UART-to-I/O-bus bridge.
//   - command byte field positions and the decoded command struct
//   - ACK/NAK response codes
//   - command FSM state encoding
//   - sub-ticks per serial bit
package uart_io_pkg;

  localparam int CMD_WR   = 7;
  localparam int CMD_RSV  = 6;
  localparam int ADDR_W   = 6;
  localparam int SUBTICKS = 8;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_DATA = 2'd1;
  localparam logic [1:0] ST_BUS      = 2'd2;
  localparam logic [1:0] ST_SEND     = 2'd3;

  typedef struct packed {
    logic              wr;
    logic              rsv;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.wr   = b[CMD_WR];
    c.rsv  = b[CMD_RSV];
    c.addr = b[ADDR_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/uart_io_master_if.sv
// uart_io_master_if: 8-bit AVR-style I/O bus.
//   io_re/io_we : single-cycle read/write strobes (initiator -> target)
//   io_a        : register address
//   io_wdata    : write data
//   io_rdata    : read data, combinational from the target while io_re is high
interface uart_io_master_if import uart_io_pkg::*; ;
  logic              io_re;
  logic              io_we;
  logic [ADDR_W-1:0] io_a;
  logic [7:0]        io_wdata;
  logic [7:0]        io_rdata;

  modport master (output io_re, output io_we, output io_a, output io_wdata, input io_rdata);
  modport slave  (input io_re, input io_we, input io_a, input io_wdata, output io_rdata);
endinterface

// File: rtl/uart_io_serdes.sv
// uart_io_serdes: 8N1 serial front end of the bridge.
//   clk, rst      : clock, asynchronous active-low reset
//   rxd / txd     : serial in (asynchronous) / serial out (idles high)
//   rx_valid/data : one-byte holding register, cleared by rx_ack
//   rx_fault      : combinational pulse on framing error or overrun
//   tx_start/data : launch a frame when the transmitter is idle
//   tx_done       : pulse in the last cycle of the stop bit
// Each direction runs its own prescaler, restarted at frame start, so bit
// phase is exact relative to the detected/launched start edge.
module uart_io_serdes import uart_io_pkg::*; #(
  parameter logic [7:0] PRESCALER = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ack,
  output logic       rx_fault,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [2:0] SUB_LAST = 3'(SUBTICKS - 1);
  localparam logic [2:0] SUB_HALF = 3'(SUBTICKS / 2 - 1);

  // synchronizer (p0, p1) then previous-sample flop (p2) for the agreement filter
  logic rxd_p0, rxd_p1, rxd_p2, rxd_f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
      rxd_f  <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
      if (rxd_p1 == rxd_p2) rxd_f <= rxd_p1;
    end
  end

  // receiver
  logic [2:0] rx_st;
  logic [7:0] rx_pre;
  logic [2:0] rx_sub;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic       rx_tick, rx_half, rx_bit_end, stop_ok, frame_err, overrun;

  assign rx_tick    = (rx_pre == PRESCALER);
  assign rx_half    = rx_tick && (rx_sub == SUB_HALF);
  assign rx_bit_end = rx_tick && (rx_sub == SUB_LAST);
  assign stop_ok    = (rx_st == RX_STOP) && rx_bit_end && rxd_f;
  assign frame_err  = (rx_st == RX_STOP) && rx_bit_end && !rxd_f;
  // an ack in the same cycle frees the holding register in time
  assign overrun    = stop_ok && rx_valid && !rx_ack;
  assign rx_fault   = frame_err || overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st    <= RX_IDLE;
      rx_pre   <= 8'd0;
      rx_sub   <= 3'd0;
      rx_bit   <= 3'd0;
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
    end else begin
      if (rx_st == RX_IDLE) begin
        rx_pre <= 8'd0;
        rx_sub <= 3'd0;
      end else begin
        rx_pre <= rx_tick ? 8'd0 : rx_pre + 8'd1;
        if (rx_tick) rx_sub <= rx_sub + 3'd1;
      end

      case (rx_st)
        RX_IDLE:  if (!rxd_f) rx_st <= RX_START;
        RX_START: if (rx_half) begin
          if (rxd_f) begin
            rx_st <= RX_IDLE;
          end else begin
            rx_st  <= RX_DATA;
            rx_sub <= 3'd0;
            rx_bit <= 3'd0;
          end
        end
        RX_DATA:  if (rx_bit_end) begin
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP:  if (rx_bit_end) rx_st <= rxd_f ? RX_IDLE : RX_WAIT;
        RX_WAIT:  if (rxd_f) rx_st <= RX_IDLE;
        default:  rx_st <= RX_IDLE;
      endcase

      if (stop_ok && !overrun) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_st == RX_DATA && rx_bit_end) rx_sh <= {rxd_f, rx_sh[7:1]};
  end

  // transmitter: bit 0 = start, 1..8 = data, 9 = stop
  logic       tx_busy;
  logic [7:0] tx_pre;
  logic [2:0] tx_sub;
  logic [3:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_tick, tx_bit_end;

  assign tx_tick    = (tx_pre == PRESCALER);
  assign tx_bit_end = tx_busy && tx_tick && (tx_sub == SUB_LAST);
  assign tx_done    = tx_bit_end && (tx_bit == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_pre  <= 8'd0;
      tx_sub  <= 3'd0;
      tx_bit  <= 4'd0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        tx_pre  <= 8'd0;
        tx_sub  <= 3'd0;
        tx_bit  <= 4'd0;
      end
    end else begin
      tx_pre <= tx_tick ? 8'd0 : tx_pre + 8'd1;
      if (tx_tick) tx_sub <= tx_sub + 3'd1;
      if (tx_bit_end) begin
        tx_bit <= tx_bit + 4'd1;
        txd    <= tx_sh[0];
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end
    end
  end

  // ones shifted in behind the data form the stop bit
  always_ff @(posedge clk) begin
    if (!tx_busy && tx_start) tx_sh <= tx_data;
    else if (tx_bit_end)      tx_sh <= {1'b1, tx_sh[7:1]};
  end

endmodule

// File: rtl/uart_io_master.sv
// uart_io_master: UART command receiver acting as initiator on the I/O bus.
//   clk, rst : clock, asynchronous active-low reset
//   rxd, txd : 8N1 serial link to the host
//   bus      : I/O bus, master side (io_re/io_we/io_a/io_wdata/io_rdata)
//   busy     : a command is being processed
//   rx_err   : registered one-cycle pulse on framing error, overrun or timeout
// Command byte: bit7 write, bit6 reserved (NAK), bits5:0 address.
// Read -> one io_re cycle, reply with the read byte; write -> wait for data
// byte, one io_we cycle, reply ACK.
module uart_io_master import uart_io_pkg::*; #(
  parameter logic [7:0] PRESCALER    = 8'd1,
  parameter logic [7:0] TIMEOUT_BITS = 8'd40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic               txd,
  uart_io_master_if.master   bus,
  output logic               busy,
  output logic               rx_err
);

  localparam int          BIT_CLKS = SUBTICKS * (int'(PRESCALER) + 1);
  localparam logic [10:0] BIT_LAST = 11'(BIT_CLKS - 1);

  logic              rx_valid, rx_ack, rx_fault, tx_start, tx_done;
  logic [7:0]        rx_data, tx_data;
  cmd_t              cmd;
  logic [1:0]        state, state_nxt;
  logic              cmd_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [10:0]       to_clk;
  logic [7:0]        to_bits;
  logic              timeout_hit;

  uart_io_serdes #(.PRESCALER(PRESCALER)) u_serdes (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .txd      (txd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ack   (rx_ack),
    .rx_fault (rx_fault),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  assign cmd = decode_cmd(rx_data);

  always_comb begin
    state_nxt   = state;
    rx_ack      = 1'b0;
    tx_start    = 1'b0;
    tx_data     = NAK;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid) begin
        rx_ack = 1'b1;
        if (cmd.rsv) begin
          state_nxt = ST_SEND;
          tx_start  = 1'b1;
        end else if (cmd.wr) begin
          state_nxt = ST_GET_DATA;
        end else begin
          state_nxt = ST_BUS;
        end
      end
      ST_GET_DATA: if (rx_valid) begin
        rx_ack    = 1'b1;
        state_nxt = ST_BUS;
      end else if (to_bits == TIMEOUT_BITS) begin
        timeout_hit = 1'b1;
        state_nxt   = ST_IDLE;
      end
      // the transmitter captures io_rdata in the strobe cycle itself
      ST_BUS: begin
        tx_start  = 1'b1;
        tx_data   = cmd_wr_q ? ACK : bus.io_rdata;
        state_nxt = ST_SEND;
      end
      ST_SEND: if (tx_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'd0;
      to_clk   <= 11'd0;
      to_bits  <= 8'd0;
      rx_err   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rx_err <= rx_fault || timeout_hit;
      if (state == ST_IDLE && rx_valid) begin
        cmd_wr_q <= cmd.wr;
        addr_q   <= cmd.addr;
      end
      if (state == ST_GET_DATA && rx_valid) wdata_q <= rx_data;
      // timeout counts whole bit periods spent waiting for the data byte
      if (state != ST_GET_DATA) begin
        to_clk  <= 11'd0;
        to_bits <= 8'd0;
      end else if (to_clk == BIT_LAST) begin
        to_clk  <= 11'd0;
        to_bits <= to_bits + 8'd1;
      end else begin
        to_clk <= to_clk + 11'd1;
      end
    end
  end

  // address/data are shown straight from the holding register in the
  // consume cycle so they are stable one cycle ahead of the strobe
  assign bus.io_a     = (state == ST_IDLE && rx_valid) ? cmd.addr : addr_q;
  assign bus.io_wdata = (state == ST_GET_DATA && rx_valid) ? rx_data : wdata_q;
  assign bus.io_re    = (state == ST_BUS) && !cmd_wr_q;
  assign bus.io_we    = (state == ST_BUS) && cmd_wr_q;
  assign busy         = (state != ST_IDLE) || rx_valid;

endmodule
